// File: rtl/complex_dot_product_engine_if.sv
// Operand/result handshake bundle for complex_dot_product_engine.
// master = operand producer / result consumer, slave = engine.
interface complex_dot_product_engine_if #(
    parameter int DATA_WIDTH = 18
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] a_r;
    logic signed [DATA_WIDTH-1:0] a_i;
    logic signed [DATA_WIDTH-1:0] b_r;
    logic signed [DATA_WIDTH-1:0] b_i;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_r;
    logic signed [DATA_WIDTH-1:0] out_i;
    logic                         out_ovf;

    modport master (
        output in_valid, a_r, a_i, b_r, b_i, out_ready,
        input  in_ready, out_valid, out_r, out_i, out_ovf
    );

    modport slave (
        input  in_valid, a_r, a_i, b_r, b_i, out_ready,
        output in_ready, out_valid, out_r, out_i, out_ovf
    );
endinterface

// File: rtl/complex_dot_product_engine.sv
// Streaming complex dot product of VEC_LEN (a,b) pairs in signed fixed point.
// Build option CDP_SATURATE_EN: saturate on narrowing instead of wrapping.
module complex_dot_product_engine #(
    parameter int INTEGER_SIZE = 7,
    parameter int FRACT_SIZE   = 11,
    parameter int DATA_WIDTH   = INTEGER_SIZE + FRACT_SIZE,
    parameter int VEC_LEN      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    complex_dot_product_engine_if.slave   bus
);
    localparam int CNT_W = $clog2(VEC_LEN) + 1;
    localparam int ACC_W = DATA_WIDTH + INTEGER_SIZE + CNT_W + 1;
    localparam int PW    = 2 * DATA_WIDTH + 1;
    localparam int TOP_W = ACC_W - DATA_WIDTH + 1;

    localparam logic signed [DATA_WIDTH-1:0] MAX_V = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] MIN_V = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {ACCUM, DRAIN, OUTPUT} state_t;

    state_t                       state;
    logic [CNT_W-1:0]             count;
    logic signed [ACC_W-1:0]      acc_r, acc_i;
    logic signed [ACC_W-1:0]      prod_r, prod_i;
    logic                         prod_valid;
    logic                         out_valid_q;
    logic signed [DATA_WIDTH-1:0] out_r_q, out_i_q;
    logic                         out_ovf_q;

    logic                         accept;
    logic signed [PW-1:0]         ar_x, ai_x, br_x, bi_x;
    logic signed [PW-1:0]         full_r, full_i, shr_r, shr_i;
    logic signed [ACC_W-1:0]      pnext_r, pnext_i;
    logic signed [ACC_W-1:0]      sum_r, sum_i;
    logic [TOP_W-1:0]             top_r, top_i;
    logic                         ovf_r, ovf_i;
    logic signed [DATA_WIDTH-1:0] red_r, red_i;

    assign bus.in_ready  = rst && (state == ACCUM);
    assign bus.out_valid = out_valid_q;
    assign bus.out_r     = out_r_q;
    assign bus.out_i     = out_i_q;
    assign bus.out_ovf   = out_ovf_q;

    assign accept = bus.in_valid && (state == ACCUM) && !flush;

    // Full-precision complex multiply, floor-shifted back to the fixed-point grid.
    always_comb begin
        ar_x    = PW'(bus.a_r);
        ai_x    = PW'(bus.a_i);
        br_x    = PW'(bus.b_r);
        bi_x    = PW'(bus.b_i);
        full_r  = ar_x * br_x - ai_x * bi_x;
        full_i  = ar_x * bi_x + ai_x * br_x;
        shr_r   = full_r >>> FRACT_SIZE;
        shr_i   = full_i >>> FRACT_SIZE;
        pnext_r = ACC_W'(shr_r);
        pnext_i = ACC_W'(shr_i);
    end

    // Running sum including any product still waiting in the stage-1 register.
    always_comb begin
        sum_r = acc_r + (prod_valid ? prod_r : '0);
        sum_i = acc_i + (prod_valid ? prod_i : '0);
        top_r = sum_r[ACC_W-1:DATA_WIDTH-1];
        top_i = sum_i[ACC_W-1:DATA_WIDTH-1];
        ovf_r = !((&top_r) || !(|top_r));
        ovf_i = !((&top_i) || !(|top_i));
`ifdef CDP_SATURATE_EN
        red_r = ovf_r ? (sum_r[ACC_W-1] ? MIN_V : MAX_V) : sum_r[DATA_WIDTH-1:0];
        red_i = ovf_i ? (sum_i[ACC_W-1] ? MIN_V : MAX_V) : sum_i[DATA_WIDTH-1:0];
`else
        red_r = sum_r[DATA_WIDTH-1:0];
        red_i = sum_i[DATA_WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ACCUM;
            count       <= '0;
            acc_r       <= '0;
            acc_i       <= '0;
            prod_r      <= '0;
            prod_i      <= '0;
            prod_valid  <= 1'b0;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            out_i_q     <= '0;
            out_ovf_q   <= 1'b0;
        end else if (flush) begin
            state       <= ACCUM;
            count       <= '0;
            acc_r       <= '0;
            acc_i       <= '0;
            prod_valid  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    acc_r      <= sum_r;
                    acc_i      <= sum_i;
                    prod_valid <= accept;
                    if (accept) begin
                        prod_r <= pnext_r;
                        prod_i <= pnext_i;
                        if (count == CNT_W'(VEC_LEN - 1)) begin
                            count <= '0;
                            state <= DRAIN;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    out_r_q     <= red_r;
                    out_i_q     <= red_i;
                    out_ovf_q   <= ovf_r || ovf_i;
                    out_valid_q <= 1'b1;
                    acc_r       <= '0;
                    acc_i       <= '0;
                    prod_valid  <= 1'b0;
                    state       <= OUTPUT;
                end
                OUTPUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_complex_dot_product_engine.sv
// Directed, table-driven bench for complex_dot_product_engine (Q7.11, VEC_LEN=4).
module tb_complex_dot_product_engine;
    localparam int IS = 7;
    localparam int FS = 11;
    localparam int DW = IS + FS;
    localparam int VL = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;

    complex_dot_product_engine_if #(.DATA_WIDTH(DW)) bus ();

    complex_dot_product_engine #(
        .INTEGER_SIZE(IS),
        .FRACT_SIZE  (FS),
        .DATA_WIDTH  (DW),
        .VEC_LEN     (VL)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string     name;
        int        a_r, a_i, b_r, b_i;
        int        exp_r, exp_i;
        bit        exp_ovf;
    } vec_t;

    vec_t tbl[9];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Present one beat and hold it until the edge that accepts it; ends 1ns after that edge.
    task automatic send_beat(input int ar, input int ai, input int br, input int bi);
        int n;
        bus.in_valid = 1'b1;
        bus.a_r = DW'(ar);
        bus.a_i = DW'(ai);
        bus.b_r = DW'(br);
        bus.b_i = DW'(bi);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_vec(input int ar, input int ai, input int br, input int bi, input int beats);
        for (int k = 0; k < beats; k++) send_beat(ar, ai, br, bi);
    endtask

    // Four beats, then exact latency and result checks with out_ready high.
    task automatic run_vec(input vec_t v);
        bus.out_ready = 1'b1;
        send_vec(v.a_r, v.a_i, v.b_r, v.b_i, VL);
        chk({v.name, "_valid_early"}, bus.out_valid, 0);
        @(posedge clk); #1;
        chk({v.name, "_valid"}, bus.out_valid, 1);
        chk({v.name, "_r"}, bus.out_r, v.exp_r);
        chk({v.name, "_i"}, bus.out_i, v.exp_i);
        chk({v.name, "_ovf"}, bus.out_ovf, v.exp_ovf);
        @(posedge clk); #1;
        chk({v.name, "_valid_drop"}, bus.out_valid, 0);
        chk({v.name, "_ready_back"}, bus.in_ready, 1);
    endtask

    initial begin
        logic signed [DW-1:0] held_r, held_i;

        tbl[0] = '{"basic",   2048,    0,  2048,     0,   8192,     0, 1'b0};
        tbl[1] = '{"conj",    2048, 2048,  2048, -2048,  16384,     0, 1'b0};
        tbl[2] = '{"mixed",   1024,  512, -2048,  3072,  -7168,  4096, 1'b0};
        tbl[3] = '{"floor",      3,    0,    -1,     0,     -4,     0, 1'b0};
        tbl[4] = '{"imag",    2048, 1024,  1024,  2048,      0, 10240, 1'b0};
        tbl[5] = '{"min_ok", -32768,   0,  2048,     0, -131072,    0, 1'b0};
`ifdef CDP_SATURATE_EN
        tbl[6] = '{"big_pos", 129024,  0, 129024,    0,  131071,    0, 1'b1};
        tbl[7] = '{"big_neg", 129024,  0, -129024,   0, -131072,    0, 1'b1};
        tbl[8] = '{"max_p1",  32768,   0,  2048,     0,  131071,    0, 1'b1};
`else
        tbl[6] = '{"big_pos", 129024,  0, 129024,    0,    8192,    0, 1'b1};
        tbl[7] = '{"big_neg", 129024,  0, -129024,   0,   -8192,    0, 1'b1};
        tbl[8] = '{"max_p1",  32768,   0,  2048,     0, -131072,    0, 1'b1};
`endif

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a_r = '0; bus.a_i = '0; bus.b_r = '0; bus.b_i = '0;

        #3 rst = 1'b0;
        #4;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_r", bus.out_r, 0);
        chk("rst_i", bus.out_i, 0);
        chk("rst_ovf", bus.out_ovf, 0);
        @(posedge clk); #3;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", bus.in_ready, 1);

        for (int t = 0; t < 9; t++) run_vec(tbl[t]);

        // Backpressure: result must hold and input stay blocked.
        bus.out_ready = 1'b0;
        send_vec(2048, 0, 2048, 0, VL);
        @(posedge clk); #1;
        chk("bp_valid", bus.out_valid, 1);
        held_r = bus.out_r;
        held_i = bus.out_i;
        chk("bp_r", held_r, 8192);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", bus.out_valid, 1);
            chk("bp_hold_r", bus.out_r, 8192);
            chk("bp_hold_i", bus.out_i, 0);
            chk("bp_hold_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", bus.out_valid, 0);
        chk("bp_release_in_ready", bus.in_ready, 1);

        // Flush mid-vector with a beat offered in the flush cycle.
        send_vec(2048, 0, 2048, 0, 2);
        bus.in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_valid", bus.out_valid, 0);
        chk("flush_keeps_r", bus.out_r, 8192);
        send_vec(1024, 0, 2048, 0, VL);
        @(posedge clk); #1;
        chk("flush_res_valid", bus.out_valid, 1);
        chk("flush_res_r", bus.out_r, 4096);
        chk("flush_res_i", bus.out_i, 0);
        @(posedge clk); #1;

        // Asynchronous reset part-way through a vector.
        send_vec(2048, 0, 2048, 0, 3);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_r", bus.out_r, 0);
        chk("arst_i", bus.out_i, 0);
        chk("arst_ovf", bus.out_ovf, 0);
        chk("arst_in_ready", bus.in_ready, 0);
        @(posedge clk); #3;
        rst = 1'b1;
        @(posedge clk); #1;
        send_vec(1024, 0, 2048, 0, VL);
        @(posedge clk); #1;
        chk("arst_res_valid", bus.out_valid, 1);
        chk("arst_res_r", bus.out_r, 4096);
        chk("arst_res_i", bus.out_i, 0);
        chk("arst_res_ovf", bus.out_ovf, 0);
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
